// File: rtl/gcd_spi_rx.sv
// gcd_spi_rx -- SPI slave receiver for the GCD result link on the je Pmod.
//
// Oversamples cs_n / mosi / sclk in the clk domain, shifts MSB-first data on
// sclk rising edges (SPI mode 0) and presents each complete DATA_W-bit word
// with a one-cycle rx_valid strobe. Frames with the wrong bit count are
// discarded and reported with a one-cycle frame_err strobe.
//
// Ports:
//   clk        in   system clock (10 MHz nominal)
//   btn        in   synchronous active-high reset
//   je[2:0]    in   je[0] = cs_n, je[1] = mosi, je[2] = sclk (asynchronous)
//   rx_data    out  last good word, held until the next good frame
//   rx_valid   out  one-cycle strobe: rx_data just updated
//   frame_err  out  one-cycle strobe: a malformed frame was dropped
//   busy       out  high while a frame is being shifted in
//   frame_cnt  out  8-bit count of good frames (only with GCD_SPI_RX_FRAME_CNT_EN)
//
// Optional feature macro: GCD_SPI_RX_FRAME_CNT_EN adds the frame_cnt port.
//
// Handshake: rx_valid is a push-only strobe with no ready; the consumer must
// capture rx_data in the cycle rx_valid is high (rx_data also holds after).
module gcd_spi_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              btn,
  input  logic [2:0]        je,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
`ifdef GCD_SPI_RX_FRAME_CNT_EN
  ,
  output logic [7:0]        frame_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  state_t state;

  // Per line: [0] first sync flop, [1] synchronized value, [2] previous
  // synchronized value for edge detection.
  logic [2:0] cs_q;
  logic [2:0] mosi_q;
  logic [2:0] sclk_q;

  always_ff @(posedge clk) begin
    if (btn) begin
      cs_q   <= 3'b111;
      mosi_q <= 3'b000;
      sclk_q <= 3'b000;
    end else begin
      cs_q   <= {cs_q[1:0], je[0]};
      mosi_q <= {mosi_q[1:0], je[1]};
      sclk_q <= {sclk_q[1:0], je[2]};
    end
  end

  logic cs_sync;
  logic cs_rise;
  logic cs_fall;
  logic sclk_rise;
  logic mosi_sync;

  assign cs_sync   = cs_q[1];
  assign cs_rise   =  cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] &  cs_q[2];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign mosi_sync =  mosi_q[1];

  // The synchronizer holds reset values (cs_n = 1) for two cycles after
  // reset release; warm gates WAIT_IDLE so it only trusts cs_sync once it
  // reflects the real pin. Otherwise a frame already in flight would look
  // like "idle, then a cs_n falling edge" and be half-received.
  logic [1:0]        warm;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic [DATA_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (btn) begin
      state     <= WAIT_IDLE;
      warm      <= 2'd0;
      cnt       <= '0;
      ovf       <= 1'b0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef GCD_SPI_RX_FRAME_CNT_EN
      frame_cnt <= 8'd0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (warm != 2'd2) warm <= warm + 2'd1;

      case (state)
        WAIT_IDLE: begin
          if (warm == 2'd2 && cs_sync) state <= IDLE;
        end

        IDLE: begin
          if (cs_fall) begin
            state <= SHIFT;
            busy  <= 1'b1;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end

        SHIFT: begin
          // cs_n rising takes priority: a coincident sclk edge is dropped.
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (cnt == FULL && !ovf) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
`ifdef GCD_SPI_RX_FRAME_CNT_EN
              frame_cnt <= frame_cnt + 8'd1;
`endif
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            shreg <= {shreg[DATA_W-2:0], mosi_sync};
            if (cnt == FULL) ovf <= 1'b1;
            else             cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_spi_rx.sv
// Testbench for gcd_spi_rx: drives SPI frames on je, a scoreboard queue holds
// the expected strobe kind and rx_data for each frame end, and a monitor pops
// and compares on every rx_valid / frame_err.
module tb_gcd_spi_rx;

  localparam int DATA_W = 8;

  logic              clk;
  logic              btn;
  logic              cs_n;
  logic              mosi;
  logic              sclk;
  logic [2:0]        je;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              busy;
`ifdef GCD_SPI_RX_FRAME_CNT_EN
  logic [7:0]        frame_cnt;
`endif

  assign je = {sclk, mosi, cs_n};

  gcd_spi_rx #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .btn       (btn),
    .je        (je),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef GCD_SPI_RX_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Entry: bit DATA_W = 1 for an expected frame_err, low bits = rx_data
  // expected in that strobe cycle.
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] last_good;
  int                exp_cnt;
  int                n_tests;
  int                n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rx_valid && frame_err) check("strobe_exclusive", 32'd1, 32'd0);
    if (rx_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, rx_valid, frame_err}, 32'd0);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        check("strobe_kind", {31'd0, frame_err}, {31'd0, e[DATA_W]});
        check("rx_data", {24'd0, rx_data}, {24'd0, e[DATA_W-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    btn = 1'b1;
    wait_clk(cycles);
    btn = 1'b0;
    last_good = '0;
    exp_cnt = 0;
  endtask

  task automatic shift_bits(input logic [31:0] val, input int first, input int last,
                            input int nbits, input int half);
    for (int i = first; i <= last; i++) begin
      mosi = val[nbits-1-i];
      wait_clk(half);
      sclk = 1'b1;
      wait_clk(half);
      sclk = 1'b0;
    end
  endtask

  // Sends one frame of nbits bits MSB first. With chk set, also checks the
  // 3-edge busy/strobe latency around the cs_n edges. gap = cs_n high cycles.
  task automatic send_frame(input logic [31:0] val, input int nbits, input int half,
                            input int gap, input bit chk);
    cs_n = 1'b0;
    if (chk) begin
      wait_clk(2);
      check("busy_rise_early", {31'd0, busy}, 32'd0);
      wait_clk(1);
      check("busy_rise", {31'd0, busy}, 32'd1);
    end else begin
      wait_clk(3);
    end
    shift_bits(val, 0, nbits - 1, nbits, half);
    wait_clk(half);
    if (nbits == DATA_W) begin
      exp_q.push_back({1'b0, val[DATA_W-1:0]});
      last_good = val[DATA_W-1:0];
      exp_cnt++;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
    cs_n = 1'b1;
    if (chk) begin
      wait_clk(2);
      check("strobe_early", {30'd0, rx_valid, frame_err}, 32'd0);
      check("busy_fall_early", {31'd0, busy}, 32'd1);
      wait_clk(1);
      check("strobe_on_time", {30'd0, rx_valid, frame_err},
            (nbits == DATA_W) ? 32'd2 : 32'd1);
      check("busy_fall", {31'd0, busy}, 32'd0);
      if (gap > 3) wait_clk(gap - 3);
    end else begin
      wait_clk(gap);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    btn = 1'b0; cs_n = 1'b1; mosi = 1'b0; sclk = 1'b0;
    n_tests = 0; n_fail = 0; exp_cnt = 0; last_good = '0;

    // Reset with cs_n idle high
    wait_clk(1);
    do_reset(2);
    wait_clk(4);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
`ifdef GCD_SPI_RX_FRAME_CNT_EN
    check("reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
`endif

    // Single frame at sclk = clk/8
    send_frame(32'h15, 8, 4, 6, 1'b1);
    check("single_hold", {24'd0, rx_data}, 32'h15);

    // Back-to-back with a 2-cycle cs_n gap
    send_frame(32'hA5, 8, 4, 2, 1'b0);
    send_frame(32'h3C, 8, 4, 6, 1'b0);
    check("b2b_last", {24'd0, rx_data}, 32'h3C);
`ifdef GCD_SPI_RX_FRAME_CNT_EN
    check("b2b_frame_cnt", {24'd0, frame_cnt}, exp_cnt);
`endif

    // Short and long frames after a good 0x15
    send_frame(32'h15, 8, 4, 6, 1'b1);
    send_frame(32'h55, 7, 4, 6, 1'b1);
    check("short_keeps_data", {24'd0, rx_data}, 32'h15);
    send_frame(32'h15, 8, 4, 6, 1'b1);
    send_frame(32'h1AA, 9, 4, 6, 1'b1);
    check("long_keeps_data", {24'd0, rx_data}, 32'h15);

    // Random good frames at assorted sclk rates
    for (int k = 0; k < 4; k++) begin
      logic [31:0] v;
      v = $urandom_range(0, 255);
      send_frame(v, 8, $urandom_range(2, 5), $urandom_range(3, 6), 1'b1);
    end

    // Reset mid-frame, cs_n held low for the rest of the frame
    cs_n = 1'b0;
    wait_clk(3);
    shift_bits(32'hF0, 0, 3, 8, 4);
    do_reset(1);
    shift_bits(32'hF0, 4, 7, 8, 4);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(6);
    check("abort_rx_data", {24'd0, rx_data}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    send_frame(32'h81, 8, 4, 6, 1'b1);
    check("after_abort", {24'd0, rx_data}, 32'h81);

`ifdef GCD_SPI_RX_FRAME_CNT_EN
    // Frame counter wrap
    do_reset(2);
    wait_clk(4);
    for (int k = 1; k <= 256; k++) begin
      send_frame(k & 32'hFF, 8, 2, 3, 1'b0);
      if (k == 255) check("frame_cnt_255", {24'd0, frame_cnt}, 32'd255);
    end
    check("frame_cnt_wrap", {24'd0, frame_cnt}, 32'd0);
`endif

    wait_clk(8);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
